rr_hold_arbiter: RTL and testbench

- Round-robin arbiter with grant hold for a single shared resource, such as a bus or UART TX port, contended by N requesters.
- A granted requester keeps ownership until it signals done, drops its request, or exceeds a hold limit.
- This is the fairness-preserving replacement for the fixed-priority arbiter when long bursts must not starve low-priority requesters.
- Sits between the requesting masters and the shared resource mux; grant_id drives the mux select.

---
 rtl/arb_pkg.sv | 40 ++++
 rtl/rr_pick_comb.sv | 34 +++
 rtl/rr_hold_arbiter.sv | 113 +++++++++++
 tb/tb_rr_hold_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// rr_pick is the scalar form of the rotate / find-first search.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_REQ_DEFAULT    = 4;
    localparam int MAX_HOLD_DEFAULT = 16;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First asserted request at or after ptr, wrapping at n (n <= 8).
    function automatic pick_t rr_pick(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input int         n
    );
        pick_t r;
        int    pos;
        r = '0;
        for (int k = n - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= n) begin
                pos = pos - n;
            end
            if (req[pos]) begin
                r.found = 1'b1;
                r.idx   = 3'(pos);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin picker: rotate req so ptr sits at bit 0,
// find the lowest set bit, then map the offset back to a requester index.
module rr_pick_comb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [N_REQ-1:0] w_rot;
    logic [ID_W:0]    w_off;
    logic [ID_W:0]    w_sum;

    // Rotate, find-first, un-rotate with explicit wrap at N_REQ.
    always_comb begin
        w_rot = N_REQ'({req, req} >> ptr);
        found = |w_rot;
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (ID_W+1)'(k);
            end
        end
        w_sum = {1'b0, ptr} + w_off;
        if (w_sum >= (ID_W+1)'(N_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(N_REQ);
        end
        idx = w_sum[ID_W-1:0];
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter that holds the grant until done, request drop,
// or the hold limit; one dead cycle follows every release.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEFAULT,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    output logic             timeout
);

    state_t           r_state, w_state_nx;
    logic [ID_W-1:0]  r_ptr, w_ptr_nx;
    logic [ID_W-1:0]  r_id, w_id_nx;
    logic [N_REQ-1:0] r_grant, w_grant_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_valid, w_valid_nx;
    logic             r_to, w_to_nx;
    logic             w_found;
    logic [ID_W-1:0]  w_pick_idx;
    logic             w_limit;
    logic             w_rel;

    rr_pick_comb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    // Next-state, pointer, hold counter and registered output values.
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_id_nx    = r_id;
        w_grant_nx = r_grant;
        w_cnt_nx   = r_cnt;
        w_valid_nx = r_valid;
        w_to_nx    = 1'b0;
        w_limit    = (r_cnt == CNT_W'(MAX_HOLD - 1));
        w_rel      = done[r_id] | ~req[r_id] | w_limit;
        case (r_state)
            IDLE: begin
                w_grant_nx = '0;
                w_id_nx    = '0;
                w_valid_nx = 1'b0;
                if (w_found) begin
                    w_state_nx = BUSY;
                    w_grant_nx = N_REQ'(1) << w_pick_idx;
                    w_id_nx    = w_pick_idx;
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = '0;
                end
            end
            BUSY: begin
                if (w_rel) begin
                    w_state_nx = IDLE;
                    w_grant_nx = '0;
                    w_id_nx    = '0;
                    w_valid_nx = 1'b0;
                    w_cnt_nx   = '0;
                    w_ptr_nx   = (r_id == ID_W'(N_REQ - 1)) ? '0
                                                              : r_id + 1'b1;
                    w_to_nx    = w_limit & ~done[r_id] & req[r_id];
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_id    <= w_id_nx;
            r_grant <= w_grant_nx;
            r_cnt   <= w_cnt_nx;
            r_valid <= w_valid_nx;
            r_to    <= w_to_nx;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_id    = r_id;
    assign timeout     = r_to;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (N_REQ=4, MAX_HOLD=16).
// Each task drives one scenario and checks its own expectations.
module tb_rr_hold_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    rr_hold_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;
        #2;
        checks++;
        if ({grant, grant_valid, grant_id, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {grant, grant_valid, grant_id, timeout}, 8'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_idle;
        req  = 4'b0000;
        done = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({grant, grant_valid, timeout} !== 6'b0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d got=%b exp=%b",
                         i, {grant, grant_valid, timeout}, 6'b0);
            end
        end
    endtask

    task automatic test_rotation;
        int seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_g;
        req  = 4'b1111;
        done = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << seq[n];
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if (grant !== exp_g || grant_valid !== 1'b1 ||
                    grant_id !== 2'(seq[n])) begin
                    errors++;
                    $display("FAIL rot_grant n=%0d c=%0d got=%b/%0d exp=%b/%0d",
                             n, c, grant, grant_id, exp_g, seq[n]);
                end
            end
            done = exp_g;
            tick();
            done = 4'b0000;
            if (n == 4) req = 4'b0000;
            checks++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0 ||
                timeout !== 1'b0) begin
                errors++;
                $display("FAIL rot_idle n=%0d got=%b v=%b to=%b exp=0000 v=0 to=0",
                         n, grant, grant_valid, timeout);
            end
        end
    endtask

    task automatic test_timeout;
        req  = 4'b0010;
        done = 4'b0000;
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (grant !== 4'b0010 || grant_valid !== 1'b1 ||
                timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold cyc=%0d got=%b v=%b to=%b exp=0010 v=1 to=0",
                         i, grant, grant_valid, timeout);
            end
            tick();
        end
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 ||
            timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse got=%b v=%b to=%b exp=0000 v=0 to=1",
                     grant, grant_valid, timeout);
        end
        tick();
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_regrant got=%b id=%0d to=%b exp=0010 id=1 to=0",
                     grant, grant_id, timeout);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_drop got=%b to=%b exp=0000 to=0",
                     grant, timeout);
        end
    endtask

    task automatic test_async_reset;
        req  = 4'b0100;
        done = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0100 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL ar_owner got=%b id=%0d exp=0100 id=2",
                     grant, grant_id);
        end
        repeat (5) tick();
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL ar_hold got=%b exp=0100", grant);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({grant, grant_valid, grant_id, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL ar_clear got=%b exp=%b",
                     {grant, grant_valid, grant_id, timeout}, 8'b0);
        end
        #1;
        req = 4'b1111;
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0001 || grant_id !== 2'd0 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_first got=%b id=%0d exp=0001 id=0",
                     grant, grant_id);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL ar_release got=%b exp=0000", grant);
        end
    endtask

    task automatic test_req_drop;
        rst = 1'b1;
        #2;
        rst  = 1'b0;
        req  = 4'b0101;
        done = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0001 || grant_id !== 2'd0) begin
                errors++;
                $display("FAIL drop_owner cyc=%0d got=%b id=%0d exp=0001 id=0",
                         c, grant, grant_id);
            end
        end
        req  = 4'b0100;
        done = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL drop_release got=%b to=%b exp=0000 to=0",
                     grant, timeout);
        end
        req = 4'b0101;
        tick();
        checks++;
        if (grant !== 4'b0100 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL drop_next got=%b id=%0d exp=0100 id=2",
                     grant, grant_id);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_done_at_limit;
        req  = 4'b1000;
        done = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL lim_owner got=%b id=%0d exp=1000 id=3",
                     grant, grant_id);
        end
        repeat (15) tick();
        checks++;
        if (grant !== 4'b1000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL lim_last got=%b to=%b exp=1000 to=0",
                     grant, timeout);
        end
        done = 4'b1000;
        tick();
        done = 4'b0000;
        req  = 4'b0000;
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 ||
            timeout !== 1'b0) begin
            errors++;
            $display("FAIL lim_release got=%b v=%b to=%b exp=0000 v=0 to=0",
                     grant, grant_valid, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_rotation();
        test_timeout();
        test_async_reset();
        test_req_drop();
        test_done_at_limit();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
